// File: rtl/register_scoreboard_if.sv
// register_scoreboard_if: issue, writeback and flush inputs plus stall/status outputs of the scoreboard.
interface register_scoreboard_if #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 32
);
  logic                       inIssueValid;
  logic [REG_ADDR_WIDTH-1:0]  inIssueRs1;
  logic [REG_ADDR_WIDTH-1:0]  inIssueRs2;
  logic [REG_ADDR_WIDTH-1:0]  inIssueRd;
  logic                       inIssueLongOp;
  logic                       inWbValid;
  logic [REG_ADDR_WIDTH-1:0]  inWbRd;
  logic                       inFlush;
  logic                       outStall;
  logic [REG_ADDR_WIDTH+1:0]  outPendingTotal;
  logic [STALL_CNT_WIDTH-1:0] outStallCycles;
  logic                       outError;
  modport master (
    output inIssueValid, inIssueRs1, inIssueRs2, inIssueRd, inIssueLongOp, inWbValid, inWbRd, inFlush,
    input  outStall, outPendingTotal, outStallCycles, outError
  );
  modport slave (
    input  inIssueValid, inIssueRs1, inIssueRs2, inIssueRd, inIssueLongOp, inWbValid, inWbRd, inFlush,
    output outStall, outPendingTotal, outStallCycles, outError
  );
endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register pending counters for long-latency producers; stalls issue on RAW/saturation hazards.
module register_scoreboard #(
  parameter int REG_COUNT       = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  register_scoreboard_if.slave bus
);
  localparam int TW = REG_ADDR_WIDTH + 2;
  logic [1:0] cnt [REG_COUNT];
  logic [TW-1:0] pendingTotal;
  logic [STALL_CNT_WIDTH-1:0] stallCycles;
  logic errorFlag;
  logic rs1Busy, rs2Busy, rdFull, stall, inc, dec, wbErr;
  always_comb begin
    // a source with a single pending write completing this cycle is satisfied by the writeback
    rs1Busy = bus.inIssueRs1 != '0 && (cnt[bus.inIssueRs1] > 2'd1 ||
              (cnt[bus.inIssueRs1] == 2'd1 && !(bus.inWbValid && bus.inWbRd == bus.inIssueRs1)));
    rs2Busy = bus.inIssueRs2 != '0 && (cnt[bus.inIssueRs2] > 2'd1 ||
              (cnt[bus.inIssueRs2] == 2'd1 && !(bus.inWbValid && bus.inWbRd == bus.inIssueRs2)));
    rdFull  = bus.inIssueLongOp && bus.inIssueRd != '0 && cnt[bus.inIssueRd] == 2'd3;
    stall   = reset && bus.inIssueValid && !bus.inFlush && (rs1Busy || rs2Busy || rdFull);
    inc     = bus.inIssueValid && !stall && !bus.inFlush && bus.inIssueLongOp && bus.inIssueRd != '0;
    dec     = bus.inWbValid && bus.inWbRd != '0 && cnt[bus.inWbRd] != 2'd0;
    wbErr   = bus.inWbValid && bus.inWbRd != '0 && cnt[bus.inWbRd] == 2'd0 && !bus.inFlush;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++) cnt[r] <= 2'd0;
      pendingTotal <= '0;
      stallCycles  <= '0;
      errorFlag    <= 1'b0;
    end else begin
      if (stall && !(&stallCycles)) stallCycles <= stallCycles + 1'b1;
      if (wbErr) errorFlag <= 1'b1;
      if (bus.inFlush) begin
        for (int r = 0; r < REG_COUNT; r++) cnt[r] <= 2'd0;
        pendingTotal <= '0;
      end else begin
        cnt[0] <= 2'd0;
        for (int r = 1; r < REG_COUNT; r++)
          cnt[r] <= cnt[r] + 2'(inc && bus.inIssueRd == REG_ADDR_WIDTH'(r))
                           - 2'(dec && bus.inWbRd == REG_ADDR_WIDTH'(r));
        pendingTotal <= pendingTotal + TW'(inc) - TW'(dec);
      end
    end
  end
  assign bus.outStall        = stall;
  assign bus.outPendingTotal = pendingTotal;
  assign bus.outStallCycles  = stallCycles;
  assign bus.outError        = errorFlag;
endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 Parameter REG_COUNT, default 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, width of register specifiers.
REQ-003 Parameter STALL_CNT_WIDTH, default 32, width of the stall-cycle statistics counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 inIssueValid  input  1  ID stage presents an instruction this cycle.
REQ-007 inIssueRs1, inIssueRs2  input  REG_ADDR_WIDTH each  source specifiers of the issuing instruction.
REQ-008 inIssueRd  input  REG_ADDR_WIDTH  destination specifier of the issuing instruction.
REQ-009 inIssueLongOp  input  1  issuing instruction writes inIssueRd through a non-forwardable producer (load, mul/div).
REQ-010 inWbValid  input  1  a long-op result is written back this cycle.
REQ-011 inWbRd  input  REG_ADDR_WIDTH  destination of that writeback.
REQ-012 inFlush  input  1  pipeline flush; discards all tracked long ops.
REQ-013 outStall  output  1  hold ID/IF; issuing instruction is not accepted.
REQ-014 outPendingTotal  output  REG_ADDR_WIDTH+2  total long-op writes in flight.
REQ-015 outStallCycles  output  STALL_CNT_WIDTH  count of cycles with outStall high.
REQ-016 outError  output  1  sticky: writeback arrived for a register with zero pending count.

Function
REQ-017 Per register r (1..REG_COUNT-1), a 2-bit pending counter cnt[r] SHALL be kept; register 0 SHALL never be tracked.
REQ-018 Short ALU producers SHALL NOT be tracked; their hazards are resolved by EX-stage forwarding.
REQ-019 Accept = inIssueValid && !outStall && !inFlush.
REQ-020 outStall SHALL be combinational and asserted when inIssueValid and any of: Rs1 nonzero with effective cnt>0; Rs2 nonzero with effective cnt>0; inIssueLongOp with Rd nonzero and cnt[Rd]==3.
REQ-021 Effective cnt for a source = cnt[rs] minus 1 if inWbValid && inWbRd==rs that cycle (writeback bypass: cnt 1 with same-cycle completion does not stall).
REQ-022 On accept with inIssueLongOp and Rd nonzero, cnt[Rd] SHALL increment next cycle.
REQ-023 On inWbValid, inWbRd nonzero, cnt[inWbRd]>0, cnt[inWbRd] SHALL decrement next cycle.
REQ-024 Simultaneous increment and decrement of the same register SHALL leave cnt unchanged.
REQ-025 inWbValid with inWbRd nonzero and cnt[inWbRd]==0 SHALL leave cnt unchanged and set outError; inWbRd==0 SHALL be ignored.
REQ-026 cnt SHALL never wrap; saturation is prevented by REQ-020.
REQ-027 outPendingTotal SHALL equal the sum of all cnt[r], updated registered with the counters.
REQ-028 inFlush SHALL clear all cnt[r] and outPendingTotal next cycle, overriding same-cycle issue and writeback; outError and outStallCycles are retained.
REQ-029 outStallCycles SHALL increment each cycle outStall is high and saturate at all-ones.
REQ-030 outStall SHALL be 0 when inIssueValid is 0 or inFlush is 1.

Reset
REQ-031 With reset low at a rising edge: all cnt[r]=0, outPendingTotal=0, outStallCycles=0, outError=0; outStall=0 while reset low.
REQ-032 Reset mid-operation SHALL discard all in-flight tracking; writebacks after reset for pre-reset issues SHALL set outError.

Verification
REQ-033 Issue long op Rd=5; next cycle issue Rs1=5 -> outStall=1, outStallCycles increments; inWbValid Rd=5 same cycle -> outStall=0, accept.
REQ-034 Three long ops to Rd=7 accepted, fourth long op to Rd=7 -> outStall=1, outPendingTotal=3; one writeback Rd=7 -> stall drops, total returns to 3 after reissue.
REQ-035 Long op Rd=0 issued, then Rs1=0 -> no stall, outPendingTotal=0.
REQ-036 Accepted long op Rd=9 and inWbValid Rd=9 (cnt=1) same cycle -> cnt[9] stays 1, outPendingTotal unchanged.
REQ-037 inWbValid Rd=12 with cnt[12]=0 -> outError=1 and stays 1 until reset.
REQ-038 Pending on Rd=3,4, inFlush with simultaneous long issue Rd=6 -> all counts 0, outPendingTotal=0, Rs1=3 next cycle does not stall.
